ps2_scancode_buffer: RTL and testbench

- Sits between ps2_controller (upstream) and morse_code_encoder (downstream).
- Filters the raw PS/2 byte stream: drops break sequences (F0 xx) and extended sequences (E0 xx / E0 F0 xx).
- Stores make codes in a FIFO and releases them to the encoder only after Enter (0x5A) is pressed, using a valid/ready handshake.
- Lets the user type a whole message before any Morse is keyed.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/scancode_fifo.sv | 62 ++++++
 rtl/ps2_scancode_buffer.sv | 110 +++++++++++
 tb/tb_ps2_scancode_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scancode constants and filter-state encoding for the PS/2 scancode buffer.
package ps2_pkg;

  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;
  localparam logic [7:0] ENTER = 8'h5A;
  localparam logic [7:0] BKSP  = 8'h66;
  localparam logic [7:0] SPACE = 8'h29;

  typedef enum logic [1:0] {
    F_NORMAL,
    F_BREAK,
    F_EXT
  } filter_state_t;

endpackage

// File: rtl/scancode_fifo.sv
// Scancode storage FIFO with push, pop and tail-decrement (unpush), plus occupancy flags.
module scancode_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              unpush,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   count_next,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic              do_push;
  logic              do_pop;
  logic              do_unpush;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign do_unpush = unpush && !empty;
  assign dout      = mem[head];

  always_comb begin
    count_next = count;
    if (do_push)   count_next = count_next + CNT_ONE;
    if (do_pop)    count_next = count_next - CNT_ONE;
    if (do_unpush) count_next = count_next - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push)   tail <= tail + PTR_ONE;
      if (do_unpush) tail <= tail - PTR_ONE;
      if (do_pop)    head <= head + PTR_ONE;
      count <= count_next;
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule

// File: rtl/ps2_scancode_buffer.sv
// Filters the PS/2 byte stream, buffers make codes and releases them on Enter via valid/ready.
// Optional backspace editing is enabled by defining PS2_BUFFER_BACKSPACE_EN.
module ps2_scancode_buffer
  import ps2_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         ADDR_W     = 4,
  parameter logic [7:0] ENTER_CODE = ENTER,
  parameter logic [7:0] BREAK_CODE = BREAK,
  parameter logic [7:0] EXT_CODE   = EXT,
  parameter logic [7:0] BKSP_CODE  = BKSP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ps2_received_data,
  input  logic              ps2_received_data_strb,
  output logic [7:0]        code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [ADDR_W:0]   fill_level,
  output logic [ADDR_W:0]   pending,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  filter_state_t   state_q, state_d;
  logic            push_ev;
  logic            release_ev;
  logic            unpush;
  logic            pop;
  logic [7:0]      fifo_dout;
  logic [ADDR_W:0] count_next;
`ifdef PS2_BUFFER_BACKSPACE_EN
  logic            bksp_ev;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    push_ev    = 1'b0;
    release_ev = 1'b0;
`ifdef PS2_BUFFER_BACKSPACE_EN
    bksp_ev    = 1'b0;
`endif
    if (ps2_received_data_strb) begin
      case (state_q)
        F_NORMAL: begin
          if (ps2_received_data == BREAK_CODE)      state_d    = F_BREAK;
          else if (ps2_received_data == EXT_CODE)   state_d    = F_EXT;
          else if (ps2_received_data == ENTER_CODE) release_ev = 1'b1;
`ifdef PS2_BUFFER_BACKSPACE_EN
          else if (ps2_received_data == BKSP_CODE)  bksp_ev    = 1'b1;
`endif
          else                                      push_ev    = 1'b1;
        end
        F_BREAK: state_d = F_NORMAL;
        F_EXT:   state_d = (ps2_received_data == BREAK_CODE) ? F_BREAK : F_NORMAL;
        default: state_d = F_NORMAL;
      endcase
    end
  end

`ifdef PS2_BUFFER_BACKSPACE_EN
  // Backspace may only erase entries the user has not yet released.
  assign unpush = bksp_ev && (fill_level > pending);
`else
  assign unpush = 1'b0;
`endif

  assign code_valid = (pending != '0);
  assign pop        = code_valid && code_ready;
  assign code_out   = code_valid ? fifo_dout : 8'h00;

  scancode_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_ev),
    .pop        (pop),
    .unpush     (unpush),
    .din        (ps2_received_data),
    .dout       (fifo_dout),
    .count      (fill_level),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= F_NORMAL;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      // Release snapshots the post-edge fill so a same-cycle pop is already accounted for.
      if (release_ev) pending <= count_next;
      else if (pop)   pending <= pending - CNT_ONE;
      if (release_ev)          overflow <= 1'b0;
      else if (push_ev && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_buffer.sv
// Directed self-checking bench for ps2_scancode_buffer with an expected-code scoreboard queue.
module tb_ps2_scancode_buffer;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic [4:0] fill_level;
  logic [4:0] pending;
  logic       full;
  logic       empty;
  logic       overflow;

  int         vectors = 0;
  int         misses  = 0;
  logic [7:0] exp_q[$];

  ps2_scancode_buffer dut (
    .clk                    (clk),
    .rst                    (rst),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .code_out               (code_out),
    .code_valid             (code_valid),
    .code_ready             (code_ready),
    .fill_level             (fill_level),
    .pending                (pending),
    .full                   (full),
    .empty                  (empty),
    .overflow               (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    step();
    ps2_received_data_strb = 1'b0;
  endtask

  task automatic send_make(input logic [7:0] b);
    exp_q.push_back(b);
    send(b);
  endtask

  // Expects n back-to-back transfers with code_ready held high.
  task automatic drain(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(code_valid), 32'd1);
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'(code_out), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_code"}, 32'(code_out), 32'(e));
      end
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code_out"}, 32'(code_out), 32'h00);
    check({tag, "_valid"},    32'(code_valid), 32'd0);
    check({tag, "_full"},     32'(full), 32'd0);
    check({tag, "_empty"},    32'(empty), 32'd1);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_fill"},     32'(fill_level), 32'd0);
    check({tag, "_pending"},  32'(pending), 32'd0);
  endtask

  initial begin
    rst                    = 1'b1;
    ps2_received_data      = 8'h00;
    ps2_received_data_strb = 1'b0;
    code_ready             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Plain stream released by Enter, drained back-to-back from Enter+1.
    code_ready = 1'b1;
    send_make(8'h1C);
    send_make(8'h29);
    send_make(8'h32);
    check("t1_fill_before_enter", 32'(fill_level), 32'd3);
    check("t1_not_valid_before_enter", 32'(code_valid), 32'd0);
    send(8'h5A);
    drain(3, "t1");
    check("t1_valid_after", 32'(code_valid), 32'd0);
    check("t1_empty_after", 32'(empty), 32'd1);

    // Break sequence drops its operand.
    send_make(8'h1C);
    send(8'hF0);
    send(8'h21);
    send_make(8'h21);
    check("t2_fill", 32'(fill_level), 32'd2);
    send(8'h5A);
    drain(2, "t2");
    check("t2_empty_after", 32'(empty), 32'd1);

    // Extended and extended-break sequences are fully discarded.
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("t3_fill_after_ext", 32'(fill_level), 32'd0);
    send_make(8'h0C);
    check("t3_fill_peak", 32'(fill_level), 32'd1);
    send(8'h5A);
    drain(1, "t3");
    check("t3_valid_after", 32'(code_valid), 32'd0);

    // Fill to DEPTH, then overflow on the 17th make code.
    for (int i = 0; i < 16; i++) begin
      send_make(8'h10 + 8'(i));
      if (i == 14) check("t4_not_full_at_15", 32'(full), 32'd0);
    end
    check("t4_full_at_16", 32'(full), 32'd1);
    check("t4_no_overflow_at_16", 32'(overflow), 32'd0);
    send(8'h30);
    check("t4_overflow_at_17", 32'(overflow), 32'd1);
    check("t4_fill_capped", 32'(fill_level), 32'd16);
    send(8'h5A);
    check("t4_overflow_cleared", 32'(overflow), 32'd0);
    check("t4_pending", 32'(pending), 32'd16);
    drain(16, "t4");
    check("t4_empty_after", 32'(empty), 32'd1);

    // Stall with code_ready low, add entries, and extend the release with a second Enter.
    code_ready = 1'b0;
    send_make(8'h21);
    send_make(8'h22);
    send(8'h5A);
    for (int i = 0; i < 10; i++) begin
      check("t5_stall_valid", 32'(code_valid), 32'd1);
      check("t5_stall_code", 32'(code_out), 32'h21);
      if (i == 3)      send_make(8'h23);
      else if (i == 6) send_make(8'h24);
      else             step();
    end
    check("t5_pending_before", 32'(pending), 32'd2);
    check("t5_fill_before", 32'(fill_level), 32'd4);
    send(8'h5A);
    check("t5_pending_extended", 32'(pending), 32'd4);
    code_ready = 1'b1;
    drain(4, "t5");
    check("t5_valid_after", 32'(code_valid), 32'd0);

    // Backspace code: erases the last unreleased entry only when the feature is built in.
    send_make(8'h1C);
`ifdef PS2_BUFFER_BACKSPACE_EN
    send(8'h32);
    send(8'h66);
    check("t6_fill_after_bksp", 32'(fill_level), 32'd1);
`else
    send_make(8'h32);
    send_make(8'h66);
    check("t6_fill_bksp_stored", 32'(fill_level), 32'd3);
`endif
    send(8'h5A);
    drain(exp_q.size(), "t6");
    check("t6_valid_after", 32'(code_valid), 32'd0);

    // Enter with an empty FIFO has no effect.
    send(8'h5A);
    check("t7_empty_enter_valid", 32'(code_valid), 32'd0);
    check("t7_empty_enter_pending", 32'(pending), 32'd0);

    // Asynchronous reset in the middle of a drain.
    send(8'h41);
    send(8'h42);
    send(8'h43);
    send(8'h44);
    send(8'h5A);
    check("t8_drain_started", 32'(code_valid), 32'd1);
    step();
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("t8_async_reset");
    step();
    rst = 1'b0;
    step();
    check_reset_outputs("t8_after_release");
    exp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
